sim_end_monitor: RTL and testbench

- Synthesizable end-of-test monitor for the rvseed core family. It replaces the ad-hoc wait/display logic in benches.
- Snoops the register-file write-back port of each hart and tracks shadow copies of the done, pass and test-number registers.
- Per hart it detects done, waits a settle window, then latches a verdict. It aggregates verdicts into sticky done/pass/fail/timeout flags.
- Generalised over hart count, XLEN, register indices, settle delay and timeout, so benches and FPGA builds can share it.

---
 rtl/sim_end_pkg.sv | 17 +
 rtl/sim_end_hart.sv | 85 ++++++++
 rtl/sim_end_monitor.sv | 109 ++++++++++
 tb/tb_sim_end_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_end_pkg.sv
// Shared types and constants for the end-of-test monitor.
// State encoding and default register indices for rvseed harts.
package sim_end_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REPORT = 2'd2
  } hart_st_t;

  localparam int DEF_DONE_REG = 26;
  localparam int DEF_PASS_REG = 27;
  localparam int DEF_TNUM_REG = 3;
  localparam int MAX_SETTLE   = 255;
  localparam int SETTLE_W     = 8;

endpackage

// File: rtl/sim_end_hart.sv
// Per-hart write-back snoop: shadow regs, settle window, verdict.
// The verdict is taken from next-state shadows to see same-edge writes.
import sim_end_pkg::*;

module sim_end_hart #(
  parameter int XLEN          = 32,
  parameter int REG_AW        = 5,
  parameter int DONE_REG      = DEF_DONE_REG,
  parameter int PASS_REG      = DEF_PASS_REG,
  parameter int TNUM_REG      = DEF_TNUM_REG,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   data,
  output logic              hart_done,
  output logic              hart_pass,
  output logic [XLEN-1:0]   testnum
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT =
    SETTLE_W'(SETTLE_CYCLES);

  hart_st_t              st;
  logic [SETTLE_W-1:0]   cnt;
  logic [XLEN-1:0]       done_sh;
  logic [XLEN-1:0]       pass_sh;
  logic [XLEN-1:0]       tnum_sh;

  logic                  hit;
  logic                  done_wr;
  logic [XLEN-1:0]       done_nx;
  logic [XLEN-1:0]       pass_nx;
  logic [XLEN-1:0]       tnum_nx;

  always_comb begin
    hit     = we && (addr != '0);
    done_wr = hit && (addr == REG_AW'(DONE_REG));
    done_nx = done_wr ? data : done_sh;
    pass_nx = (hit && addr == REG_AW'(PASS_REG))
            ? data : pass_sh;
    tnum_nx = (hit && addr == REG_AW'(TNUM_REG))
            ? data : tnum_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_RUN;
      cnt       <= '0;
      done_sh   <= '0;
      pass_sh   <= '0;
      tnum_sh   <= '0;
      hart_done <= 1'b0;
      hart_pass <= 1'b0;
      testnum   <= '0;
    end else begin
      done_sh <= done_nx;
      pass_sh <= pass_nx;
      tnum_sh <= tnum_nx;
      unique case (st)
        ST_RUN: begin
          if (done_wr && done_nx == XLEN'(1)) begin
            st  <= ST_SETTLE;
            cnt <= SETTLE_INIT;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_W'(1)) begin
            st        <= ST_REPORT;
            hart_done <= 1'b1;
            hart_pass <= (pass_nx == XLEN'(1));
            testnum   <= tnum_nx;
          end else begin
            cnt <= cnt - SETTLE_W'(1);
          end
        end
        ST_REPORT: ;
        default: st <= ST_RUN;
      endcase
    end
  end

endmodule

// File: rtl/sim_end_monitor.sv
// End-of-test monitor: per-hart verdicts, aggregation, cycle timeout.
// Timeout takes priority over done when both would set together.
import sim_end_pkg::*;

module sim_end_monitor #(
  parameter int NUM_HARTS      = 1,
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int DONE_REG       = DEF_DONE_REG,
  parameter int PASS_REG       = DEF_PASS_REG,
  parameter int TNUM_REG       = DEF_TNUM_REG,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [NUM_HARTS-1:0]        wb_we,
  input  logic [NUM_HARTS*REG_AW-1:0] wb_addr,
  input  logic [NUM_HARTS*XLEN-1:0]   wb_data,
  output logic [NUM_HARTS-1:0]        hart_done,
  output logic [NUM_HARTS-1:0]        hart_pass,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic [((NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1)-1:0]
                                      fail_hart,
  output logic [XLEN-1:0]             fail_testnum,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [XLEN-1:0]      tnum [NUM_HARTS];
  logic [NUM_HARTS-1:0] fail_vec;
  logic [HW-1:0]        pick_idx;
  logic [XLEN-1:0]      pick_tnum;
  logic                 cnt_en;
  logic [CNT_W-1:0]     cnt_nx;
  logic                 tmo_set;
  logic                 done_set;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    sim_end_hart #(
      .XLEN          (XLEN),
      .REG_AW        (REG_AW),
      .DONE_REG      (DONE_REG),
      .PASS_REG      (PASS_REG),
      .TNUM_REG      (TNUM_REG),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_hart (
      .clk       (clk),
      .rst       (rst),
      .we        (wb_we[h]),
      .addr      (wb_addr[h*REG_AW +: REG_AW]),
      .data      (wb_data[h*XLEN +: XLEN]),
      .hart_done (hart_done[h]),
      .hart_pass (hart_pass[h]),
      .testnum   (tnum[h])
    );
  end

  // Scan high to low so the lowest failing hart wins.
  always_comb begin
    fail_vec  = hart_done & ~hart_pass;
    pick_idx  = '0;
    pick_tnum = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (fail_vec[i]) begin
        pick_idx  = HW'(i);
        pick_tnum = tnum[i];
      end
    end
  end

  always_comb begin
    cnt_en   = run && !done && !timeout;
    cnt_nx   = (&cycle_count) ? cycle_count
             : cycle_count + CNT_W'(1);
    tmo_set  = cnt_en &&
               (cnt_nx == CNT_W'(TIMEOUT_CYCLES));
    done_set = (&hart_done) && !timeout && !tmo_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_hart    <= '0;
      fail_testnum <= '0;
      cycle_count  <= '0;
    end else begin
      if (cnt_en)   cycle_count <= cnt_nx;
      if (tmo_set)  timeout     <= 1'b1;
      if (done_set) done        <= 1'b1;
      pass <= done_set && (&hart_pass);
      if (!fail && |fail_vec) begin
        fail         <= 1'b1;
        fail_hart    <= pick_idx;
        fail_testnum <= pick_tnum;
      end
    end
  end

endmodule

// File: tb/tb_sim_end_monitor.sv
// Scoreboard bench: one single-hart and one four-hart monitor.
// Expectations are queued with stimulus and drained after edges.
module tb_sim_end_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, run1;
  logic [0:0]  we1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic [0:0]  hd1, hp1, fh1;
  logic        done1, pass1, fail1, tmo1;
  logic [31:0] ft1, cc1;

  logic         rst4, run4;
  logic [3:0]   we4;
  logic [19:0]  addr4;
  logic [127:0] data4;
  logic [3:0]   hd4, hp4;
  logic         done4, pass4, fail4, tmo4;
  logic [1:0]   fh4;
  logic [31:0]  ft4, cc4;

  sim_end_monitor #(
    .NUM_HARTS(1), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(20)
  ) u_one (
    .clk(clk), .rst(rst1), .run(run1),
    .wb_we(we1), .wb_addr(addr1), .wb_data(data1),
    .hart_done(hd1), .hart_pass(hp1),
    .done(done1), .pass(pass1), .fail(fail1),
    .timeout(tmo1), .fail_hart(fh1),
    .fail_testnum(ft1), .cycle_count(cc1)
  );

  sim_end_monitor #(
    .NUM_HARTS(4), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(1000)
  ) u_four (
    .clk(clk), .rst(rst4), .run(run4),
    .wb_we(we4), .wb_addr(addr4), .wb_data(data4),
    .hart_done(hd4), .hart_pass(hp4),
    .done(done4), .pass(pass4), .fail(fail4),
    .timeout(tmo4), .fail_hart(fh4),
    .fail_testnum(ft4), .cycle_count(cc4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [63:0] val_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0:  return 64'(hd1);
      1:  return 64'(hp1);
      2:  return 64'(done1);
      3:  return 64'(pass1);
      4:  return 64'(fail1);
      5:  return 64'(tmo1);
      6:  return 64'(fh1);
      7:  return 64'(ft1);
      8:  return 64'(cc1);
      10: return 64'(hd4);
      11: return 64'(hp4);
      12: return 64'(done4);
      13: return 64'(pass4);
      14: return 64'(fail4);
      15: return 64'(tmo4);
      16: return 64'(fh4);
      17: return 64'(ft4);
      18: return 64'(cc4);
      default: return '1;
    endcase
  endfunction

  task automatic want(input string tag, input int sel,
                      input logic [63:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(v);
  endtask

  task automatic drain();
    while (sel_q.size() > 0) begin
      string       t;
      int          s;
      logic [63:0] v;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      chk(t, observe(s), v);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    we1 = 1'b1; addr1 = a; data1 = d;
    step();
    we1 = 1'b0; addr1 = '0; data1 = '0;
  endtask

  task automatic pulse1();
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
  endtask

  task automatic set4(input int h, input logic [4:0] a,
                      input logic [31:0] d);
    we4[h] = 1'b1;
    addr4[h*5 +: 5] = a;
    data4[h*32 +: 32] = d;
  endtask

  task automatic clr4();
    we4 = '0; addr4 = '0; data4 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    rst1 = 1'b1; run1 = 1'b0;
    we1 = '0; addr1 = '0; data1 = '0;
    rst4 = 1'b1; run4 = 1'b0;
    clr4();
    step(2);
    rst1 = 1'b0; rst4 = 1'b0;

    for (int s = 0; s <= 8; s++) want("rst_one", s, 0);
    for (int s = 10; s <= 18; s++) want("rst_four", s, 0);
    drain();

    // basic pass, 1 hart
    run1 = 1'b1;
    wr1(27, 1);
    wr1(26, 1);
    want("p_settle_hd", 0, 0);
    drain();
    step();
    want("p_hd", 0, 1); want("p_hp", 1, 1);
    want("p_done_lag", 2, 0);
    drain();
    step();
    want("p_done", 2, 1); want("p_pass", 3, 1);
    want("p_fail", 4, 0); want("p_tmo", 5, 0);
    drain();
    step();
    want("p_cc_frozen", 8, 4);
    drain();

    // fail with test number
    pulse1();
    wr1(3, 5);
    wr1(26, 1);
    wr1(27, 0);
    want("f_hd", 0, 1); want("f_hp", 1, 0);
    want("f_fail_lag", 4, 0);
    drain();
    step();
    want("f_fail", 4, 1); want("f_tnum", 7, 5);
    want("f_hart", 6, 0); want("f_pass", 3, 0);
    want("f_done", 2, 1);
    drain();

    // pass write on the verdict edge is forwarded
    pulse1();
    wr1(26, 1);
    wr1(27, 1);
    want("fw_hd", 0, 1); want("fw_hp", 1, 1);
    drain();
    step();
    want("fw_pass", 3, 1);
    drain();

    // bad done value, x0 write, reset mid-settle
    pulse1();
    wr1(26, 2);
    wr1(0, 1);
    step(2);
    want("bad_done_hd", 0, 0);
    drain();
    wr1(26, 1);
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    for (int s = 0; s <= 8; s++) want("midrst", s, 0);
    drain();
    step(2);
    want("midrst_hd", 0, 0);
    drain();
    wr1(27, 1);
    wr1(26, 1);
    step(2);
    want("after_rst_pass", 3, 1);
    drain();

    // timeout and counter freeze
    pulse1();
    step(19);
    want("t_cc19", 8, 19); want("t_tmo19", 5, 0);
    drain();
    step();
    want("t_cc20", 8, 20); want("t_tmo", 5, 1);
    drain();
    step(3);
    want("t_cc_hold", 8, 20); want("t_done0", 2, 0);
    drain();
    wr1(26, 1);
    step();
    want("t_late_hd", 0, 1);
    drain();
    step();
    want("t_late_done", 2, 0); want("t_late_pass", 3, 0);
    drain();

    // last report on the timeout edge: timeout wins
    pulse1();
    step(18);
    wr1(26, 1);
    step();
    want("tie_hd", 0, 1); want("tie_tmo", 5, 1);
    drain();
    step();
    want("tie_done", 2, 0); want("tie_tmo2", 5, 1);
    drain();

    // four harts; shadows update with run low
    set4(0, 27, 1); set4(1, 27, 1);
    step();
    clr4();
    step(2);
    want("q_cc_hold", 18, 0);
    drain();
    run4 = 1'b1;
    set4(2, 3, 7); set4(3, 3, 9);
    step();
    clr4();
    set4(0, 26, 1); set4(2, 26, 1); set4(3, 26, 1);
    step();
    clr4();
    step();
    set4(1, 26, 1);
    step();
    clr4();
    want("q_hd_a2", 10, 0);
    drain();
    step();
    want("q_hd_a3", 10, 4'b1101); want("q_hp_a3", 11, 4'b0001);
    want("q_fail_a3", 14, 0);
    drain();
    step();
    want("q_fail", 14, 1); want("q_fhart", 16, 2);
    want("q_ftnum", 17, 7); want("q_done_a4", 12, 0);
    drain();
    step();
    want("q_hd_all", 10, 4'b1111); want("q_hp_all", 11, 4'b0011);
    drain();
    step();
    want("q_done", 12, 1); want("q_pass", 13, 0);
    want("q_fhart_keep", 16, 2); want("q_ftnum_keep", 17, 7);
    want("q_tmo", 15, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
